// File: rtl/frame_pkg.sv
// Shared constants and write-side FSM type for the AXI-Stream frame FIFO.
// Frames are a magic header beat, a timestamp beat and 35 data beats.
package frame_pkg;

  localparam logic [63:0] MAGIC_NUMBER = 64'hDEADBEEFCAFEBABE;
  localparam int FRAME_BEATS = 37;
  localparam int DATA_BEATS  = 35;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    DROP
  } wr_state_e;

endpackage

// File: rtl/frame_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on storage or read register so it maps onto block RAM.
module frame_fifo_ram #(
  parameter int WIDTH  = 65,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward frame FIFO: only complete, header-valid frames
// reach the DMA; frames that cannot be held whole are dropped.
module axis_frame_fifo
  import frame_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 7,
  parameter int MAX_BEATS = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic              magic_check_en,
  input  logic              clear_stats,
  output logic [31:0]       frames_in,
  output logic [31:0]       frames_out,
  output logic [31:0]       frames_dropped,
  output logic [31:0]       bad_header,
  output logic [ADDR_W:0]   occupancy,
  output logic              overflow_seen
);

  localparam int PW = ADDR_W + 1;
  localparam int CW = $clog2(MAX_BEATS) + 2;
  localparam logic [PW-1:0] DEPTH = PW'(2**ADDR_W);
  localparam logic [CW-1:0] MAXB  = CW'(MAX_BEATS);
  localparam logic [DATA_W-1:0] MAGIC = DATA_W'(MAGIC_NUMBER);

  wr_state_e state, state_n;

  logic [PW-1:0] wr_ptr, wr_ptr_n;
  logic [PW-1:0] wr_commit, commit_n;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt, cnt_n;

  logic rdy, accept, full, magic_bad;
  logic wr_en, rd_en, m_valid;
  logic inc_in, inc_drop, inc_bad, set_ovf, inc_out;
  logic [DATA_W:0] q;

  assign s_axis_tready = rdy;
  assign accept    = s_axis_tvalid & rdy;
  assign full      = (wr_ptr - rd_ptr) == DEPTH;
  assign magic_bad = magic_check_en && (s_axis_tdata != MAGIC);
  assign occupancy = wr_commit - rd_ptr;

  always_comb begin
    state_n  = state;
    wr_en    = 1'b0;
    wr_ptr_n = wr_ptr;
    commit_n = wr_commit;
    cnt_n    = cnt;
    inc_in   = 1'b0;
    inc_drop = 1'b0;
    inc_bad  = 1'b0;
    set_ovf  = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (magic_bad) begin
            inc_bad  = 1'b1;
            inc_drop = 1'b1;
            state_n  = s_axis_tlast ? IDLE : DROP;
          end else if (full) begin
            // committed frames can fill the RAM exactly
            inc_drop = 1'b1;
            set_ovf  = 1'b1;
            state_n  = s_axis_tlast ? IDLE : DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            cnt_n    = CW'(1);
            if (s_axis_tlast) begin
              commit_n = wr_ptr + 1'b1;
              inc_in   = 1'b1;
            end else begin
              state_n = ACCEPT;
            end
          end
        end
        ACCEPT: begin
          if (full || cnt >= MAXB) begin
            wr_ptr_n = wr_commit;
            inc_drop = 1'b1;
            set_ovf  = full;
            state_n  = s_axis_tlast ? IDLE : DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            cnt_n    = cnt + 1'b1;
            if (s_axis_tlast) begin
              commit_n = wr_ptr + 1'b1;
              inc_in   = 1'b1;
              state_n  = IDLE;
            end
          end
        end
        DROP: begin
          if (s_axis_tlast)
            state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
      cnt       <= '0;
      rdy       <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      wr_commit <= commit_n;
      cnt       <= cnt_n;
      rdy       <= 1'b1;
    end
  end

  // the RAM read register doubles as the output stage
  assign rd_en = (rd_ptr != wr_commit) && (!m_valid || m_axis_tready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr  <= '0;
      m_valid <= 1'b0;
    end else if (rd_en) begin
      rd_ptr  <= rd_ptr + 1'b1;
      m_valid <= 1'b1;
    end else if (m_axis_tready) begin
      m_valid <= 1'b0;
    end
  end

  assign m_axis_tvalid = m_valid;
  assign m_axis_tdata  = m_valid ? q[DATA_W-1:0] : '0;
  assign m_axis_tlast  = m_valid & q[DATA_W];
  assign inc_out = m_valid & m_axis_tready & q[DATA_W];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frames_in      <= '0;
      frames_out     <= '0;
      frames_dropped <= '0;
      bad_header     <= '0;
      overflow_seen  <= 1'b0;
    end else if (clear_stats) begin
      frames_in      <= '0;
      frames_out     <= '0;
      frames_dropped <= '0;
      bad_header     <= '0;
      overflow_seen  <= 1'b0;
    end else begin
      frames_in      <= frames_in + 32'(inc_in);
      frames_out     <= frames_out + 32'(inc_out);
      frames_dropped <= frames_dropped + 32'(inc_drop);
      bad_header     <= bad_header + 32'(inc_bad);
      overflow_seen  <= overflow_seen | set_ovf;
    end
  end

  frame_fifo_ram #(
    .WIDTH  (DATA_W + 1),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tdata}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (q)
  );

endmodule
